pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 97 +++++++++
 tb/tb_pipe_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-register stall/hold, exception redirect flush, stall-cycle counter.
// Define PIPE_CTRL_PERF_EN to build the saturating stall_cycles counter; otherwise the port is tied to 0.
module pipe_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            stall_req,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  output logic [4:0]            stall,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic [PERF_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] target;
  logic                  take_exc;
  logic [4:0]            req_stall;

  // Hold every register up to and including the highest requesting stage.
  always_comb begin
    req_stall = '0;
    if (stall_req[3])      req_stall = 5'b01111;
    else if (stall_req[2]) req_stall = 5'b00111;
    else if (stall_req[1]) req_stall = 5'b00011;
    else if (stall_req[0]) req_stall = 5'b00001;
  end

  assign take_exc = exc_req && ((state == IDLE) || (state == DRAIN));

  always_comb begin
    state_nxt = state;
    stall     = req_stall;
    flush     = 1'b0;
    unique case (state)
      IDLE: begin
        if (exc_req) state_nxt = stall_req[3] ? PEND : FLUSH;
      end
      PEND: begin
        stall = 5'b01111;
        if (!stall_req[3]) state_nxt = FLUSH;
      end
      FLUSH: begin
        stall     = '0;
        flush     = 1'b1;
        state_nxt = stall_req[0] ? DRAIN : IDLE;
      end
      DRAIN: begin
        stall = 5'b00001;
        if (exc_req)            state_nxt = stall_req[3] ? PEND : FLUSH;
        else if (!stall_req[0]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      target <= '0;
    end else begin
      state <= state_nxt;
      // Only IDLE/DRAIN accept a redirect, so the first target in PEND wins.
      if (take_exc) target <= exc_pc;
    end
  end

  assign flush_pc = target;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_WIDTH-1:0] cycle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (stall[0] && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + PERF_WIDTH'(1);
    end
  end

  assign stall_cycles = cycle_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned PW = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    stall_req;
  logic          exc_req;
  logic [AW-1:0] exc_pc;
  logic [4:0]    stall;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [PW-1:0] stall_cycles;

  pipe_ctrl #(.ADDR_WIDTH(AW), .PERF_WIDTH(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .exc_req      (exc_req),
    .exc_pc       (exc_pc),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: a redirect is either waiting on MEM, being flushed now, or draining a wrong-path fetch.
  bit            m_pend;
  bit            m_flush;
  bit            m_drain;
  logic [AW-1:0] m_target;
  int unsigned   m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] therm(input logic [3:0] sr);
    int h;
    h = -1;
    for (int i = 0; i < 4; i++) if (sr[i]) h = i;
    return 5'((1 << (h + 1)) - 1);
  endfunction

  task automatic model_reset();
    m_pend   = 0;
    m_flush  = 0;
    m_drain  = 0;
    m_target = '0;
    m_cnt    = 0;
  endtask

  task automatic step(input logic [3:0] sr, input logic ex, input logic [AW-1:0] pc);
    logic [4:0] exp_stall;
    @(negedge clk);
    stall_req = sr;
    exc_req   = ex;
    exc_pc    = pc;
    #1;
    if (m_flush)      exp_stall = 5'b00000;
    else if (m_pend)  exp_stall = 5'b01111;
    else if (m_drain) exp_stall = 5'b00001;
    else              exp_stall = therm(sr);
    check("stall", 64'(stall), 64'(exp_stall));
    check("flush", 64'(flush), 64'(m_flush));
    check("flush_pc", 64'(flush_pc), 64'(m_target));
    check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
    @(posedge clk);
`ifdef PIPE_CTRL_PERF_EN
    if (exp_stall[0] && m_cnt < (2**PW - 1)) m_cnt++;
`endif
    if (m_flush) begin
      m_flush = 0;
      m_drain = sr[0];
    end else if (m_pend) begin
      if (!sr[3]) begin
        m_pend  = 0;
        m_flush = 1;
      end
    end else if (ex) begin
      m_target = pc;
      m_drain  = 0;
      if (sr[3]) m_pend = 1;
      else       m_flush = 1;
    end else if (m_drain && !sr[0]) begin
      m_drain = 0;
    end
  endtask

  task automatic do_reset();
    logic [3:0] sr;
    @(negedge clk);
    sr        = 4'($urandom_range(0, 15));
    stall_req = sr;
    exc_req   = 1'b0;
    rst       = 1'b0;
    model_reset();
    #1;
    check("rst_stall", 64'(stall), 64'(therm(sr)));
    check("rst_flush", 64'(flush), 64'(0));
    check("rst_flush_pc", 64'(flush_pc), 64'(0));
    check("rst_cycles", 64'(stall_cycles), 64'(0));
    @(posedge clk);
    #1;
    check("rst_flush_hold", 64'(flush), 64'(0));
    check("rst_cycles_hold", 64'(stall_cycles), 64'(0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    stall_req = '0;
    exc_req   = 1'b0;
    exc_pc    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // EX busy for three cycles
    repeat (3) step(4'b0100, 1'b0, '0);
    step(4'b0000, 1'b0, '0);

    // Immediate redirect
    step(4'b0000, 1'b1, 32'hBFC0_0380);
    step(4'b0000, 1'b0, '0);
    step(4'b0000, 1'b0, '0);

    // Redirect behind a busy MEM; a second request in PEND is ignored
    step(4'b1000, 1'b1, 32'hA000_0000);
    repeat (3) step(4'b1000, 1'b1, 32'h0000_1234);
    step(4'b0000, 1'b0, '0);
    step(4'b0001, 1'b0, '0);
    step(4'b0001, 1'b0, '0);
    step(4'b0000, 1'b0, '0);
    step(4'b0000, 1'b0, '0);

    // Redirect taken from DRAIN
    step(4'b0000, 1'b1, 32'h8000_0180);
    step(4'b0001, 1'b0, '0);
    step(4'b0001, 1'b1, 32'h8000_0200);
    step(4'b0000, 1'b0, '0);
    step(4'b0000, 1'b0, '0);

    // Reset mid-PEND abandons the redirect
    step(4'b1000, 1'b1, 32'h0000_0055);
    step(4'b1000, 1'b0, '0);
    do_reset();
    step(4'b0000, 1'b0, '0);
    step(4'b0000, 1'b0, '0);

    // Reset mid-DRAIN
    step(4'b0000, 1'b1, 32'h0000_0077);
    step(4'b0001, 1'b0, '0);
    step(4'b0001, 1'b0, '0);
    do_reset();
    step(4'b0001, 1'b0, '0);

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] sr;
      logic       ex;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        sr[0] = ($urandom_range(0, 2) == 0);
        sr[1] = ($urandom_range(0, 4) == 0);
        sr[2] = ($urandom_range(0, 4) == 0);
        sr[3] = ($urandom_range(0, 3) == 0);
        ex    = ($urandom_range(0, 5) == 0);
        step(sr, ex, AW'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
